// File: rtl/heartbeat_pkg.sv
// Shared constants for the heartbeat bank: channel mode encodings and per-channel reset defaults.
package heartbeat_pkg;

  localparam logic [1:0] HB_PULSE  = 2'b00;
  localparam logic [1:0] HB_SQUARE = 2'b01;
  localparam logic [1:0] HB_PWM    = 2'b10;
  localparam logic [1:0] HB_RSVD   = 2'b11;

  localparam logic       HB_RST_EN   = 1'b1;
  localparam logic [1:0] HB_RST_MODE = HB_PULSE;
  // Period resets to all ones (2^N-1), duty to zero; replicated to width N where used.
  localparam logic       HB_RST_PERIOD_BIT = 1'b1;
  localparam logic       HB_RST_DUTY_BIT   = 1'b0;

endpackage

// File: rtl/heartbeat_chan.sv
// One heartbeat channel: N-bit wrapping counter, active+shadow config, registered out/tick.
// out/tick lag the counter by one cycle; a pending shadow blocks new writes until it is applied.
module heartbeat_chan
  import heartbeat_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         sync,
  input  logic         wr,
  input  logic         wr_en,
  input  logic [1:0]   wr_mode,
  input  logic [N-1:0] wr_period,
  input  logic [N-1:0] wr_duty,
  output logic         pending,
  output logic         out,
  output logic         tick
);

  typedef struct packed {
    logic         en;
    logic [1:0]   mode;
    logic [N-1:0] period;
    logic [N-1:0] duty;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    en:     HB_RST_EN,
    mode:   HB_RST_MODE,
    period: {N{HB_RST_PERIOD_BIT}},
    duty:   {N{HB_RST_DUTY_BIT}}
  };

  logic [N-1:0] cnt_q, cnt_d;
  cfg_t         act_q, act_d;
  cfg_t         shd_q, shd_d;
  cfg_t         wr_cfg;
  logic         pend_q, pend_d;
  logic         tog_q, tog_d;
  logic         out_q, out_d;
  logic         tick_q, tick_d;
  logic         wrap;
  logic         apply;

  assign wr_cfg = '{en: wr_en, mode: wr_mode, period: wr_period, duty: wr_duty};

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    tog_d  = tog_q;
    out_d  = 1'b0;
    tick_d = 1'b0;
    wrap   = act_q.en && (cnt_q == act_q.period);
    // Shadow only swaps in at a period boundary, so no partial periods are ever produced.
    apply  = pend_q && (sync || wrap || !act_q.en);

    if (act_q.en) begin
      cnt_d  = wrap ? '0 : cnt_q + 1'b1;
      tog_d  = tog_q ^ wrap;
      tick_d = wrap;
      case (act_q.mode)
        HB_PULSE:  out_d = wrap;
        HB_SQUARE: out_d = tog_q ^ wrap;
        HB_PWM:    out_d = (cnt_q < act_q.duty);
        HB_RSVD:   out_d = 1'b0;
      endcase
    end else begin
      cnt_d = '0;
      tog_d = 1'b0;
    end

    if (apply) begin
      act_d  = shd_q;
      pend_d = 1'b0;
      if (shd_q.mode != act_q.mode) tog_d = 1'b0;
    end

    if (sync) begin
      cnt_d  = '0;
      tog_d  = 1'b0;
      out_d  = 1'b0;
      tick_d = 1'b0;
    end

    // A write is only granted while nothing is pending, so it never collides with apply.
    if (wr) begin
      shd_d  = wr_cfg;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q  <= '0;
      act_q  <= CFG_RST;
      shd_q  <= CFG_RST;
      pend_q <= 1'b0;
      tog_q  <= 1'b0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      tog_q  <= tog_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign pending = pend_q;
  assign out     = out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/heartbeat_bank.sv
// NCH-channel programmable heartbeat/blink generator with a shadowed config write port.
// out/tick registered; cfg_ready drops per channel while that channel still holds an unapplied write.
module heartbeat_bank
  import heartbeat_pkg::*;
#(
  parameter  int N   = 8,
  parameter  int NCH = 4,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           sync,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic           cfg_en,
  input  logic [1:0]     cfg_mode,
  input  logic [N-1:0]   cfg_period,
  input  logic [N-1:0]   cfg_duty,
  output logic [NCH-1:0] out,
  output logic [NCH-1:0] tick
);

  logic [NCH-1:0] pending;
  logic [NCH-1:0] wr;

  // Out-of-range channel indices match nothing: ready stays high and the write is dropped.
  always_comb begin
    cfg_ready = 1'b1;
    wr        = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CW'(i)) begin
        cfg_ready = !pending[i];
        wr[i]     = cfg_valid && !pending[i];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    heartbeat_chan #(
      .N(N)
    ) u_chan (
      .clk       (clk),
      .nreset    (nreset),
      .sync      (sync),
      .wr        (wr[g]),
      .wr_en     (cfg_en),
      .wr_mode   (cfg_mode),
      .wr_period (cfg_period),
      .wr_duty   (cfg_duty),
      .pending   (pending[g]),
      .out       (out[g]),
      .tick      (tick[g])
    );
  end

endmodule

// File: tb/tb_heartbeat_bank.sv
// Directed bench for heartbeat_bank: per-cycle compare against a period/phase model plus literal checks.
`timescale 1ns/1ps
module tb_heartbeat_bank;
  import heartbeat_pkg::*;

  localparam int N   = 8;
  localparam int NCH = 5;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           nreset;
  logic           sync;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_ch;
  logic           cfg_en;
  logic [1:0]     cfg_mode;
  logic [N-1:0]   cfg_period;
  logic [N-1:0]   cfg_duty;
  logic [NCH-1:0] out;
  logic [NCH-1:0] tick;

  heartbeat_bank #(.N(N), .NCH(NCH)) dut (
    .clk(clk), .nreset(nreset), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .out(out), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: each channel is a phase within its current period, a wrap count and a config pair.
  int         m_ph[NCH], m_per[NCH], m_duty[NCH], m_wraps[NCH];
  logic [1:0] m_mode[NCH], s_mode[NCH];
  bit         m_en[NCH], m_pend[NCH], s_en[NCH];
  int         s_per[NCH], s_duty[NCH];
  logic [NCH-1:0] exp_out, exp_tick;
  int         cyc;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_ph[c] = 0; m_en[c] = 1'b1; m_mode[c] = HB_PULSE; m_per[c] = (1 << N) - 1;
      m_duty[c] = 0; m_wraps[c] = 0; m_pend[c] = 1'b0;
      s_en[c] = 1'b1; s_mode[c] = HB_PULSE; s_per[c] = 0; s_duty[c] = 0;
    end
    exp_out = '0; exp_tick = '0; cyc = 0;
  endtask

  task automatic model_step();
    int acc, old_ph;
    bit at_end;
    acc = -1;
    if (cfg_valid && int'(cfg_ch) < NCH) begin
      if (!m_pend[cfg_ch]) acc = int'(cfg_ch);
    end
    for (int c = 0; c < NCH; c++) begin
      old_ph = m_ph[c];
      at_end = m_en[c] && (m_ph[c] == m_per[c]);
      if (sync || !m_en[c]) begin
        m_ph[c] = 0; m_wraps[c] = 0;
      end else begin
        m_ph[c] = (m_ph[c] + 1) % (m_per[c] + 1);
        if (at_end) m_wraps[c]++;
      end
      if (!m_en[c] || sync) begin
        exp_out[c] = 1'b0; exp_tick[c] = 1'b0;
      end else begin
        exp_tick[c] = at_end;
        case (m_mode[c])
          HB_PULSE:  exp_out[c] = at_end;
          HB_SQUARE: exp_out[c] = (m_wraps[c] % 2) == 1;
          HB_PWM:    exp_out[c] = old_ph < m_duty[c];
          default:   exp_out[c] = 1'b0;
        endcase
      end
      if (m_pend[c] && (sync || at_end || !m_en[c])) begin
        if (s_mode[c] != m_mode[c]) m_wraps[c] = 0;
        m_en[c] = s_en[c]; m_mode[c] = s_mode[c]; m_per[c] = s_per[c]; m_duty[c] = s_duty[c];
        m_pend[c] = 1'b0;
      end
      if (acc == c) begin
        s_en[c] = cfg_en; s_mode[c] = cfg_mode; s_per[c] = int'(cfg_period); s_duty[c] = int'(cfg_duty);
        m_pend[c] = 1'b1;
      end
    end
    cyc++;
  endtask

  function automatic logic exp_ready();
    if (int'(cfg_ch) >= NCH) return 1'b1;
    return !m_pend[cfg_ch];
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge nreset);
      if (!nreset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model out", {27'd0, out}, {27'd0, exp_out});
      chk("model tick", {27'd0, tick}, {27'd0, exp_tick});
      chk("model cfg_ready", {31'd0, cfg_ready}, {31'd0, exp_ready()});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish within 1ms");
    $fatal(1);
  end

  task automatic cfg_write(input int ch, input bit en, input logic [1:0] mode,
                           input int per, input int duty, output int acc_edge);
    int w;
    @(posedge clk); #2;
    cfg_valid = 1'b1; cfg_ch = CW'(ch); cfg_en = en; cfg_mode = mode;
    cfg_period = N'(per); cfg_duty = N'(duty);
    acc_edge = -1;
    w = 0;
    while (acc_edge < 0 && w < 2000) begin
      @(negedge clk);
      if (cfg_ready) acc_edge = cyc + 1;
      @(posedge clk); #2;
      w++;
    end
    cfg_valid = 1'b0;
    chk("cfg_write accepted", {31'd0, acc_edge >= 0}, 32'd1);
  endtask

  task automatic wait_tick(input int ch, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit && at < 0; i++) begin
      @(negedge clk);
      if (tick[ch]) at = cyc;
    end
  endtask

  task automatic count_hi(input int ch, input bit use_tick, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cnt += use_tick ? int'(tick[ch]) : int'(out[ch]);
    end
  endtask

  task automatic measure_runs(input int ch, output int hi, output int lo);
    int i;
    i = 0;
    do begin @(negedge clk); i++; end while (out[ch] !== 1'b0 && i < 64);
    i = 0;
    do begin @(negedge clk); i++; end while (out[ch] !== 1'b1 && i < 64);
    hi = 1;
    while (hi < 64) begin
      @(negedge clk);
      if (out[ch]) hi++; else break;
    end
    lo = 1;
    while (lo < 64) begin
      @(negedge clk);
      if (!out[ch]) lo++; else break;
    end
  endtask

  initial begin
    int at, acc, acc2, hi, lo, cnt, s;
    nreset = 1'b0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0;
    cfg_en = 1'b0; cfg_mode = 2'b00; cfg_period = '0; cfg_duty = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("reset out", {27'd0, out}, 32'd0);
    chk("reset tick", {27'd0, tick}, 32'd0);
    chk("reset cfg_ready", {31'd0, cfg_ready}, 32'd1);
    @(posedge clk); #2;
    nreset = 1'b1;

    // Default heartbeat: first pulse 256 cycles after release, on every channel
    wait_tick(0, 300, at);
    chk("T1 first tick cycle", at, 256);
    chk("T1 all out", {27'd0, out}, 32'h1F);
    chk("T1 all tick", {27'd0, tick}, 32'h1F);

    // Square on ch1, then a second write held off until the ch1 wrap
    cfg_write(1, 1'b1, HB_SQUARE, 3, 0, acc);
    chk("T2 accept edge", acc, 258);
    @(negedge clk);
    chk("T2 ready low while pending", {31'd0, cfg_ready}, 32'd0);
    cfg_write(1, 1'b1, HB_SQUARE, 3, 0, acc2);
    chk("T4 held write accept edge", acc2, 513);
    measure_runs(1, hi, lo);
    chk("T2 square high run", hi, 4);
    chk("T2 square low run", lo, 4);

    // PWM on ch2, period 9
    cfg_write(2, 1'b1, HB_PWM, 9, 3, acc);
    wait_tick(2, 400, at);
    chk("T3 ch2 apply wrap", at, 768);
    chk("T3 ch0 tick unaffected", {31'd0, tick[0]}, 32'd1);
    measure_runs(2, hi, lo);
    chk("T3 pwm duty3 high run", hi, 3);
    chk("T3 pwm duty3 low run", lo, 7);
    cfg_write(2, 1'b1, HB_PWM, 9, 0, acc);
    repeat (12) @(posedge clk);
    count_hi(2, 1'b0, 20, cnt);
    chk("T3 pwm duty0 ones", cnt, 0);
    cfg_write(2, 1'b1, HB_PWM, 9, 12, acc);
    repeat (12) @(posedge clk);
    count_hi(2, 1'b0, 20, cnt);
    chk("T3 pwm duty12 ones", cnt, 20);

    // sync with a pending ch3 shadow, plus a same-cycle write to ch0
    cfg_write(3, 1'b1, HB_PULSE, 4, 0, acc);
    @(posedge clk); #2;
    sync = 1'b1; cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_en = 1'b1;
    cfg_mode = HB_PULSE; cfg_period = 8'd0; cfg_duty = 8'd0;
    @(negedge clk);
    chk("T5 ready during sync", {31'd0, cfg_ready}, 32'd1);
    s = cyc + 1;
    @(posedge clk); #2;
    sync = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    chk("T5 ch0 pending after sync", {31'd0, cfg_ready}, 32'd0);
    wait_tick(3, 20, at);
    chk("T5 ch3 tick after sync", at, s + 5);
    chk("T5 tick vector", {27'd0, tick}, 32'h08);
    wait_tick(2, 20, at);
    chk("T5 ch2 tick after sync", at, s + 10);
    wait_tick(0, 300, at);
    chk("T5 ch0 tick after sync", at, s + 256);
    count_hi(0, 1'b0, 16, cnt);
    chk("T6 period0 pulse constant", cnt, 16);

    // Disable ch1, then re-enable while disabled
    cfg_write(1, 1'b0, HB_SQUARE, 3, 0, acc);
    repeat (6) @(posedge clk);
    count_hi(1, 1'b0, 12, cnt);
    chk("T6 disabled out", cnt, 0);
    count_hi(1, 1'b1, 12, cnt);
    chk("T6 disabled tick", cnt, 0);
    cfg_write(1, 1'b1, HB_PULSE, 1, 0, acc);
    @(negedge clk);
    chk("T6 pending while disabled", {31'd0, cfg_ready}, 32'd0);
    @(negedge clk);
    chk("T6 applied next cycle", {31'd0, cfg_ready}, 32'd1);
    wait_tick(1, 10, at);
    chk("T6 re-enabled tick", at, acc + 3);

    // Out-of-range channel write is dropped
    @(posedge clk); #2;
    cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_en = 1'b0; cfg_mode = HB_PWM; cfg_period = 8'd2;
    @(negedge clk);
    chk("T6 ready for cfg_ch=NCH", {31'd0, cfg_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #2 cfg_valid = 1'b0;
    count_hi(0, 1'b0, 8, cnt);
    chk("T6 ch0 untouched by dropped write", cnt, 8);

    // Asynchronous reset mid-period
    @(posedge clk); #2;
    @(negedge clk);
    chk("T6 out0 before reset", {31'd0, out[0]}, 32'd1);
    #2 nreset = 1'b0;
    #1;
    chk("T6 async reset out", {27'd0, out}, 32'd0);
    chk("T6 async reset tick", {27'd0, tick}, 32'd0);
    @(posedge clk); #2;
    nreset = 1'b1; cfg_ch = 3'd0;
    wait_tick(0, 300, at);
    chk("T6 default restored after reset", at, 256);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
